riscv_top: RTL and testbench
============================

Name: riscv_top

Overview:
- Single-cycle RV32I-subset + M-subset integer processor top level.
- Fetches one 32-bit instruction per clock from an external, combinational instruction memory.
- Decodes and executes the instruction, then writes the result into a 32x32 register file.
- No data memory and no branches; the PC advances sequentially.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, number of architectural registers.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rstn  input  1  reset, synchronous and active-high (asserted = 1, sampled on rising clk; the port name is kept as used in the codebase).
- instr_addr  output  32  current PC, i.e. the byte address of the instruction being executed.
- instr  input  32  instruction word at instr_addr. It is combinational from instr_addr and is valid in the same cycle.

Behaviour:
- Reset (rstn=1 at a rising edge):
  - PC <= RESET_PC, so instr_addr=0.
  - All registers x0..x31 <= 0.
  - No writeback happens in that cycle.
- Reset asserted mid-program: the next edge restores the full reset state; there is no partial retirement.
- Each rising edge with rstn=0:
  - The instruction on instr is executed.
  - rd is written if it is a writing instruction and rd!=0.
  - PC <= PC+4, wrapping modulo 2^32. No stalls; latency is exactly 1 cycle per instruction.
- Register file:
  - Two asynchronous read ports (rs1=instr[19:15], rs2=instr[24:20]) and one synchronous write port.
  - x0 always reads 0; writes to it are ignored.
  - Read-during-write returns the old value; the new value is visible next cycle.
  - Register storage is an array named registers, inside an instance reg_bk, inside a core instance cpu. Benches probe cpu.reg_bk.registers[i].
- Supported instructions, rd=instr[11:7]:
  - LUI (0110111): rd = {instr[31:12], 12'b0}.
  - OP-IMM (0010011), sign-extended imm[11:0]:
    - ADDI, SLTI, SLTIU, XORI, ORI, ANDI.
    - SLLI, SRLI, SRAI, with shamt=instr[24:20]; SRAI is selected by instr[30].
  - OP (0110011), funct7=0000000:
    - ADD, SLL, SLT (signed), SLTU, XOR, SRL, OR, AND.
    - All shifts use rs2[4:0].
  - OP (0110011), funct7=0100000: SUB (funct3 000), SRA (funct3 101).
  - OP (0110011), funct7=0000001:
    - MUL (000): low 32 bits of the product.
    - DIV (100), DIVU (101), REM (110, signed, result takes the sign of the dividend), REMU (111).
  - Divide by zero: DIV returns -1, DIVU returns 2^32-1, REM/REMU return the dividend.
  - Signed overflow (-2^31 / -1): DIV returns -2^31, REM returns 0.
- Any other encoding, including 32'h0000_0000, is a NOP: no register write, PC+4.
- All arithmetic wraps at 32 bits; no traps or exceptions.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants (OPC_LUI, OPC_OPIMM, OPC_OP);
  - funct3/funct7 constants;
  - alu_op_t enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, DIV, DIVU, REM, REMU, PASS_B);
  - XLEN.
- Hierarchy:
  - riscv_top instantiates core cpu.
  - cpu contains the PC, the decoder and the ALU, and instantiates reg_file as reg_bk.
- reg_file is the natural standalone sub-module; the ALU may be a function or a block.

Test Plan:
- Reset then ADDI x15,x0,170; ADDI x14,x0,85; ADDI x1,x0,1 -> x15=170, x14=85, x1=1, with instr_addr stepping 0,4,8 one per clock.
- ADD x12,x14,x15 / AND x10,x15,x14 / OR x11,x14,x15 / SUB x10,x11,x14 / XOR x14,x1,x14 -> 255, 0, 255, 170, 84.
- x15=10, x14=4:
  - SLL x10,x15,x14 -> 160; SRL x10,x10,x14 -> 10.
  - LUI x15,0xFFFFF -> x15=32'hFFFF_F000 (-4096).
  - SRL x20,x15,x14 -> 32'h0FFF_FF00; SRA x21,x15,x14 -> 32'hFFFF_FF00.
- Compares with x15=-4096, x14=4: SLT x26,x15,x14 -> 1; SLTU x26,x15,x14 -> 0; SLTU x26,x14,x15 -> 1.
- M-extension:
  - MUL x26,x14,x14 -> 16; ADDI x26,x26,4 -> 20; ADDI x14,x14,4 -> 8; REM x26,x26,x14 -> 4.
  - DIV by 0 -> 32'hFFFF_FFFF; REM -7,2 -> -1.
- Edge cases:
  - ADDI x0,x0,5 -> x0 stays 0.
  - instr=0 -> no register change.
  - rstn asserted mid-program -> next edge instr_addr=0 and all registers 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings and ALU operation set for the single-cycle RV32I/M-subset core.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_MUL  = 3'b000;
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_PASS_B
    } alu_op_t;

endpackage

// File: rtl/riscv_core.sv
// Single-cycle core: PC, decoder and ALU, with the register file instantiated as reg_bk.
module core #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstn,
    output logic [XLEN-1:0] instr_addr,
    input  logic [31:0]     instr
);
    import riscv_pkg::*;

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] pc;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_u, op_b, result;
    logic            rf_we;
    alu_op_t         alu_op;

    function automatic logic [XLEN-1:0] alu(input alu_op_t op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa, sb;
        logic                   div_zero, div_ovf;
        logic [XLEN-1:0]        res;
        sa       = a;
        sb       = b;
        div_zero = (b == '0);
        div_ovf  = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        case (op)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_SLL:  res = a << b[SHW-1:0];
            ALU_SLT:  res = {{(XLEN-1){1'b0}}, sa < sb};
            ALU_SLTU: res = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  res = a ^ b;
            ALU_SRL:  res = a >> b[SHW-1:0];
            ALU_SRA:  res = $unsigned(sa >>> b[SHW-1:0]);
            ALU_OR:   res = a | b;
            ALU_AND:  res = a & b;
            ALU_MUL:  res = a * b;
            // Divide-by-zero and -2^31/-1 give fixed results instead of trapping.
            ALU_DIV:  res = div_zero ? '1 : (div_ovf ? a : $unsigned(sa / sb));
            ALU_DIVU: res = div_zero ? '1 : a / b;
            ALU_REM:  res = div_zero ? a : (div_ovf ? '0 : $unsigned(sa % sb));
            ALU_REMU: res = div_zero ? a : a % b;
            default:  res = b;
        endcase
        return res;
    endfunction

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];
    assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_u  = XLEN'({instr[31:12], 12'b0});

    always_comb begin
        alu_op = ALU_ADD;
        op_b   = rs2_val;
        rf_we  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                alu_op = ALU_PASS_B;
                op_b   = imm_u;
                rf_we  = 1'b1;
            end
            OPC_OPIMM: begin
                op_b  = imm_i;
                rf_we = 1'b1;
                case (funct3)
                    F3_ADD:  alu_op = ALU_ADD;
                    F3_SLT:  alu_op = ALU_SLT;
                    F3_SLTU: alu_op = ALU_SLTU;
                    F3_XOR:  alu_op = ALU_XOR;
                    F3_OR:   alu_op = ALU_OR;
                    F3_AND:  alu_op = ALU_AND;
                    F3_SLL: begin
                        alu_op = ALU_SLL;
                        rf_we  = (funct7 == F7_BASE);
                    end
                    default: begin
                        alu_op = instr[30] ? ALU_SRA : ALU_SRL;
                        rf_we  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    rf_we = 1'b1;
                    case (funct3)
                        F3_ADD:  alu_op = ALU_ADD;
                        F3_SLL:  alu_op = ALU_SLL;
                        F3_SLT:  alu_op = ALU_SLT;
                        F3_SLTU: alu_op = ALU_SLTU;
                        F3_XOR:  alu_op = ALU_XOR;
                        F3_SRL:  alu_op = ALU_SRL;
                        F3_OR:   alu_op = ALU_OR;
                        default: alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == F3_ADD) begin
                        alu_op = ALU_SUB;
                        rf_we  = 1'b1;
                    end else if (funct3 == F3_SRL) begin
                        alu_op = ALU_SRA;
                        rf_we  = 1'b1;
                    end
                end else if (funct7 == F7_MULDIV) begin
                    rf_we = 1'b1;
                    case (funct3)
                        F3_MUL:  alu_op = ALU_MUL;
                        F3_DIV:  alu_op = ALU_DIV;
                        F3_DIVU: alu_op = ALU_DIVU;
                        F3_REM:  alu_op = ALU_REM;
                        F3_REMU: alu_op = ALU_REMU;
                        default: rf_we  = 1'b0;
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign result = alu(alu_op, rs1_val, op_b);

    always_ff @(posedge clk) begin
        if (rstn) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc + XLEN'(4);
        end
    end

    assign instr_addr = pc;

    reg_file #(.XLEN(XLEN), .NREGS(NREGS)) reg_bk (
        .clk      (clk),
        .rstn     (rstn),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .wr_en    (rf_we),
        .rd_addr  (rd),
        .rd_data  (result)
    );

endmodule

// File: rtl/riscv_reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous write port, x0 hardwired to 0.
module reg_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wr_en,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data
);

    logic [XLEN-1:0] registers [NREGS];

    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < NREGS; i++) begin
                registers[i] <= '0;
            end
        end else if (wr_en && (rd_addr != 5'd0)) begin
            registers[rd_addr] <= rd_data;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write shows up next cycle.
    assign rs1_data = (rs1_addr == 5'd0) ? '0 : registers[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : registers[rs2_addr];

endmodule

// File: rtl/riscv_top.sv
// Top level of the single-cycle integer processor; instruction memory sits outside.
module riscv_top #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rstn,
    output logic [XLEN-1:0] instr_addr,
    input  logic [31:0]     instr
);

    core #(.XLEN(XLEN), .NREGS(NREGS), .RESET_PC(RESET_PC)) cpu (
        .clk        (clk),
        .rstn       (rstn),
        .instr_addr (instr_addr),
        .instr      (instr)
    );

endmodule

// File: tb/tb_riscv_top.sv
// Directed bench for riscv_top: expected writebacks queued at issue, checked against the register file after the edge.
module tb_riscv_top;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] instr;
    logic [31:0] instr_addr;

    always #5 clk = ~clk;

    riscv_top dut (
        .clk        (clk),
        .rstn       (rstn),
        .instr_addr (instr_addr),
        .instr      (instr)
    );

    typedef struct {
        string       tag;
        int          rd;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] shadow [32];
    logic [31:0] pc_exp;
    int          checks   = 0;
    int          failures = 0;

    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPIMM = 7'b0010011;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], OP};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                          input int rd);
        return {imm[11:0], rs1[4:0], f3, rd[4:0], OPIMM};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd);
        return {imm20[19:0], rd[4:0], 7'b0110111};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // rd < 0 means: compare the whole register file against the shadow copy.
    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.rd < 0) begin
                for (int i = 0; i < 32; i++) begin
                    check($sformatf("%s_x%0d", e.tag, i), dut.cpu.reg_bk.registers[i], shadow[i]);
                end
            end else begin
                check(e.tag, dut.cpu.reg_bk.registers[e.rd], e.val);
            end
        end
    endtask

    task automatic exec(input logic [31:0] ins, input string tag, input int rd,
                        input logic [31:0] val);
        instr = ins;
        check({tag, "_pc"}, instr_addr, pc_exp);
        sb_q.push_back('{tag, rd, val});
        if (rd > 0) shadow[rd] = val;
        @(posedge clk);
        #1;
        pc_exp = pc_exp + 32'd4;
        drain();
    endtask

    task automatic do_reset(input logic [31:0] ins, input string tag);
        rstn  = 1'b1;
        instr = ins;
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        sb_q.push_back('{tag, -1, 32'd0});
        @(posedge clk);
        #1;
        rstn   = 1'b0;
        pc_exp = 32'd0;
        check({tag, "_pc"}, instr_addr, pc_exp);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn   = 1'b1;
        instr  = '0;
        pc_exp = '0;
        #1;
        do_reset(32'd0, "reset");

        exec(enc_i(170, 0, 3'b000, 15), "addi_x15", 15, 32'd170);
        exec(enc_i(85, 0, 3'b000, 14),  "addi_x14", 14, 32'd85);
        exec(enc_i(1, 0, 3'b000, 1),    "addi_x1",  1,  32'd1);

        exec(enc_r(7'h00, 15, 14, 3'b000, 12), "add",  12, 32'd255);
        exec(enc_r(7'h00, 14, 15, 3'b111, 10), "and",  10, 32'd0);
        exec(enc_r(7'h00, 15, 14, 3'b110, 11), "or",   11, 32'd255);
        exec(enc_r(7'h20, 14, 11, 3'b000, 10), "sub",  10, 32'd170);
        exec(enc_r(7'h00, 14, 1, 3'b100, 14),  "xor",  14, 32'd84);

        exec(enc_i(10, 0, 3'b000, 15), "set_x15", 15, 32'd10);
        exec(enc_i(4, 0, 3'b000, 14),  "set_x14", 14, 32'd4);
        exec(enc_r(7'h00, 14, 15, 3'b001, 10), "sll", 10, 32'd160);
        exec(enc_r(7'h00, 14, 10, 3'b101, 10), "srl", 10, 32'd10);
        exec(enc_u(20'hFFFFF, 15),             "lui", 15, 32'hFFFF_F000);
        exec(enc_r(7'h00, 14, 15, 3'b101, 20), "srl_neg", 20, 32'h0FFF_FF00);
        exec(enc_r(7'h20, 14, 15, 3'b101, 21), "sra_neg", 21, 32'hFFFF_FF00);

        exec(enc_r(7'h00, 14, 15, 3'b010, 26), "slt",   26, 32'd1);
        exec(enc_r(7'h00, 14, 15, 3'b011, 26), "sltu0", 26, 32'd0);
        exec(enc_r(7'h00, 15, 14, 3'b011, 26), "sltu1", 26, 32'd1);

        exec(enc_r(7'h01, 14, 14, 3'b000, 26), "mul",     26, 32'd16);
        exec(enc_i(4, 26, 3'b000, 26),         "addi_26", 26, 32'd20);
        exec(enc_i(4, 14, 3'b000, 14),         "addi_14", 14, 32'd8);
        exec(enc_r(7'h01, 14, 26, 3'b110, 26), "rem",     26, 32'd4);
        exec(enc_r(7'h01, 0, 26, 3'b100, 27),  "div_z",   27, 32'hFFFF_FFFF);
        exec(enc_r(7'h01, 0, 26, 3'b101, 28),  "divu_z",  28, 32'hFFFF_FFFF);
        exec(enc_r(7'h01, 0, 26, 3'b111, 29),  "remu_z",  29, 32'd4);
        exec(enc_r(7'h01, 0, 26, 3'b110, 30),  "rem_z",   30, 32'd4);

        exec(enc_i(-7, 0, 3'b000, 5),          "set_m7",  5, 32'hFFFF_FFF9);
        exec(enc_i(2, 0, 3'b000, 6),           "set_2",   6, 32'd2);
        exec(enc_r(7'h01, 6, 5, 3'b110, 7),    "rem_neg", 7, 32'hFFFF_FFFF);
        exec(enc_r(7'h01, 6, 5, 3'b100, 8),    "div_neg", 8, 32'hFFFF_FFFD);
        exec(enc_r(7'h01, 6, 5, 3'b111, 3),    "remu",    3, 32'd1);

        exec(enc_u(20'h80000, 9),              "lui_min",  9,  32'h8000_0000);
        exec(enc_i(-1, 0, 3'b000, 10),         "set_m1",   10, 32'hFFFF_FFFF);
        exec(enc_r(7'h01, 10, 9, 3'b100, 11),  "div_ovf",  11, 32'h8000_0000);
        exec(enc_r(7'h01, 10, 9, 3'b110, 12),  "rem_ovf",  12, 32'd0);

        exec(enc_i(32'h404, 9, 3'b101, 13),    "srai",  13, 32'hF800_0000);
        exec(enc_i(4, 9, 3'b101, 16),          "srli",  16, 32'h0800_0000);
        exec(enc_i(31, 1, 3'b001, 22),         "slli",  22, 32'h8000_0000);
        exec(enc_i(-6, 5, 3'b010, 17),         "slti",  17, 32'd1);
        exec(enc_i(1, 5, 3'b011, 18),          "sltiu", 18, 32'd0);
        exec(enc_i(255, 5, 3'b111, 19),        "andi",  19, 32'h0000_00F9);
        exec(enc_i(-1, 0, 3'b110, 23),         "ori",   23, 32'hFFFF_FFFF);
        exec(enc_i(3, 6, 3'b100, 24),          "xori",  24, 32'd1);

        exec(enc_i(5, 0, 3'b000, 0),           "x0_write", 0, 32'd0);
        exec(enc_i(1, 1, 3'b000, 1),           "rdw_x1",   1, 32'd2);
        exec(32'h0000_0000,                    "nop_zero", -1, 32'd0);
        exec(enc_r(7'h20, 1, 1, 3'b001, 25),   "bad_f7",   -1, 32'd0);
        exec(enc_r(7'h01, 1, 1, 3'b001, 25),   "mulh_nop", -1, 32'd0);

        do_reset(enc_i(7, 0, 3'b000, 1), "mid_reset");
        exec(enc_i(3, 0, 3'b000, 2), "post_reset", 2, 32'd3);
        check("final_pc", instr_addr, pc_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
